// File: rtl/ifu_prefetch_if.sv
// rtl/ifu_prefetch_if.sv - memory, consumer, redirect and perf signals of the prefetch unit
interface ifu_prefetch_if #(
    parameter int XLEN = 32
);
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_rsp_valid;
    logic [31:0]     mem_rsp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_pc;
    logic [31:0]     inst;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [31:0]     perf_fetch_cnt;
    logic [31:0]     perf_flush_cnt;

    modport master (
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output inst_valid, inst_pc, inst,
        input  inst_ready, redirect_valid, redirect_pc,
        output perf_fetch_cnt, perf_flush_cnt
    );

    modport slave (
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  inst_valid, inst_pc, inst,
        output inst_ready, redirect_valid, redirect_pc,
        input  perf_fetch_cnt, perf_flush_cnt
    );
endinterface

// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - instruction prefetch buffer; IFU_PREFETCH_PERF_EN enables perf counters
module ifu_prefetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000,
    parameter int              DEPTH    = 4
) (
    input logic          clk,
    input logic          rst,
    ifu_prefetch_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   in_flight;
    logic [CW-1:0]   occ;
    logic [CW-1:0]   stale;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [31:0]     data_mem [DEPTH];

    logic [CW:0]     used;
    logic            req_valid;
    logic            accept;
    logic            rsp_take;
    logic            rsp_drop;
    logic            push;
    logic            pop;
    logic [CW-1:0]   in_flight_next;

    // Requests are only issued when a buffer slot is reserved for the response.
    assign used      = {1'b0, in_flight} + {1'b0, occ};
    assign req_valid = !rst && !bus.redirect_valid && (used < (CW+1)'(DEPTH));
    assign accept    = req_valid && bus.mem_req_ready;

    // A response with nothing outstanding belongs to a request issued before reset.
    assign rsp_take  = bus.mem_rsp_valid && (in_flight != '0);
    assign rsp_drop  = rsp_take && (bus.redirect_valid || (stale != '0));
    assign push      = rsp_take && !rsp_drop;
    assign pop       = (occ != '0) && bus.inst_ready && !bus.redirect_valid;

    assign in_flight_next = in_flight + CW'(accept) - CW'(rsp_take);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc  <= RESET_PC;
            rsp_pc    <= RESET_PC;
            in_flight <= '0;
            occ       <= '0;
            stale     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            in_flight <= in_flight_next;
            if (bus.redirect_valid) begin
                // Everything still outstanding after this cycle belongs to the old path.
                fetch_pc <= bus.redirect_pc;
                rsp_pc   <= bus.redirect_pc;
                occ      <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                stale    <= in_flight_next;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (push) begin
                    rsp_pc <= rsp_pc + XLEN'(4);
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                occ <= occ + CW'(push) - CW'(pop);
                if (rsp_take && (stale != '0)) begin
                    stale <= stale - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= rsp_pc;
            data_mem[wr_ptr] <= bus.mem_rsp_data;
        end
    end

    assign bus.mem_req_valid = req_valid;
    assign bus.mem_req_addr  = fetch_pc;
    assign bus.inst_valid    = !rst && (occ != '0);
    assign bus.inst_pc       = pc_mem[rd_ptr];
    assign bus.inst          = data_mem[rd_ptr];

`ifdef IFU_PREFETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (accept) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (bus.redirect_valid) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

    assign bus.perf_fetch_cnt = fetch_cnt;
    assign bus.perf_flush_cnt = flush_cnt;
`else
    assign bus.perf_fetch_cnt = '0;
    assign bus.perf_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb/tb_ifu_prefetch.sv - scoreboard bench for ifu_prefetch with a variable-latency memory model
module tb_ifu_prefetch;
    logic clk;
    logic rst;

    ifu_prefetch_if #(.XLEN(32)) bus ();

    ifu_prefetch #(
        .XLEN(32),
        .RESET_PC(32'h8000_0000),
        .DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_t;

    mem_t        mq[$];
    logic [31:0] exp_q[$];
    int          lat = 1;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    int          base;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic consume(input int budget);
        int n;
        n = 0;
        bus.inst_ready = 1'b1;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL consume_timeout: %0d entries still expected after %0d cycles", exp_q.size(), budget);
            exp_q.delete();
        end
        bus.inst_ready = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        tick();
        bus.redirect_valid = 1'b0;
    endtask

    // Memory: in-order responses, lat cycles after acceptance, at most one per cycle.
    initial begin
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                mq.push_back('{addr: bus.mem_req_addr, due: cyc + lat});
                acc_cnt++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rsp_data  = inst_of(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                bus.mem_rsp_valid = 1'b0;
            end
        end
    end

    // Monitor: every delivered instruction is matched against the scoreboard.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst && bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got pc %h, nothing expected", bus.inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_pc", bus.inst_pc, e);
                    chk("pop_inst", bus.inst, inst_of(e));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                = 1'b1;
        bus.mem_req_ready  = 1'b1;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;

        repeat (3) tick();
        @(negedge clk);
        chk("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_perf_fetch", bus.perf_fetch_cnt, 32'd0);
        chk("rst_perf_flush", bus.perf_flush_cnt, 32'd0);

        // Reset release with a 1-cycle memory
        tick();
        rst  = 1'b0;
        base = acc_cnt;
        @(negedge clk);
        chk("c0_req_valid", 32'(bus.mem_req_valid), 32'd1);
        chk("c0_addr", bus.mem_req_addr, 32'h8000_0000);
        chk("c0_inst_valid", 32'(bus.inst_valid), 32'd0);
        @(negedge clk);
        chk("c1_addr", bus.mem_req_addr, 32'h8000_0004);
        chk("c1_inst_valid", 32'(bus.inst_valid), 32'd0);
        @(negedge clk);
        chk("c2_addr", bus.mem_req_addr, 32'h8000_0008);
        chk("c2_inst_valid", 32'(bus.inst_valid), 32'd1);
        chk("c2_inst_pc", bus.inst_pc, 32'h8000_0000);
        chk("c2_inst", bus.inst, inst_of(32'h8000_0000));

        // Stalled consumer: credit limit stops fetch at DEPTH
        repeat (8) tick();
        chk("full_accepts", 32'(acc_cnt - base), 32'd4);
        @(negedge clk);
        chk("full_req_valid", 32'(bus.mem_req_valid), 32'd0);
        tick();
        exp_q.push_back(32'h8000_0000);
        consume(20);
        repeat (6) tick();
        chk("one_pop_one_req", 32'(acc_cnt - base), 32'd5);
        @(negedge clk);
        chk("refull_req_valid", 32'(bus.mem_req_valid), 32'd0);
        tick();
        for (int i = 1; i <= 4; i++) exp_q.push_back(32'h8000_0000 + 32'(4 * i));
        consume(20);

        // Redirect with two requests in flight on a 4-cycle memory
        lat = 4;
        redirect(32'h8000_0200);
        repeat (20) tick();
        exp_q.push_back(32'h8000_0200);
        exp_q.push_back(32'h8000_0204);
        consume(40);
        tick();
        redirect(32'h8000_0100);
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h8000_0100 + 32'(4 * i));
        consume(60);

        // Memory back-pressure holds the request stable
        bus.mem_req_ready = 1'b0;
        redirect(32'h8000_0400);
        repeat (10) tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(bus.mem_req_valid), 32'd1);
            chk("stall_addr", bus.mem_req_addr, 32'h8000_0400);
        end
        tick();
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        chk("stall_accept_addr", bus.mem_req_addr, 32'h8000_0400);
        tick();
        bus.mem_req_ready = 1'b0;
        @(negedge clk);
        chk("stall_next_valid", 32'(bus.mem_req_valid), 32'd1);
        chk("stall_next_addr", bus.mem_req_addr, 32'h8000_0404);

        // Address wrap at the top of the address space
        tick();
        redirect(32'hFFFF_FFFC);
        repeat (10) tick();
        @(negedge clk);
        chk("wrap_addr_top", bus.mem_req_addr, 32'hFFFF_FFFC);
        tick();
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        @(negedge clk);
        chk("wrap_valid", 32'(bus.mem_req_valid), 32'd1);
        chk("wrap_addr_zero", bus.mem_req_addr, 32'h0000_0000);
        tick();
        bus.mem_req_ready = 1'b1;
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        consume(60);

        // Reset with requests outstanding, then back-to-back redirects and counted fetches
        lat = 3;
        repeat (2) tick();
        rst               = 1'b1;
        bus.mem_req_ready = 1'b0;
        @(negedge clk);
        chk("rst2_req_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("rst2_inst_valid", 32'(bus.inst_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("rst2_perf_fetch", bus.perf_fetch_cnt, 32'd0);
        chk("rst2_perf_flush", bus.perf_flush_cnt, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        redirect(32'h8000_0800);
        redirect(32'h8000_0900);
        base = acc_cnt;
        for (int i = 0; i < 10; i++) exp_q.push_back(32'h8000_0900 + 32'(4 * i));
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.mem_req_ready = 1'b1;
            tick();
            bus.mem_req_ready = 1'b0;
            tick();
        end
        consume(100);
        chk("perf_phase_accepts", 32'(acc_cnt - base), 32'd10);
`ifdef IFU_PREFETCH_PERF_EN
        chk("perf_fetch_cnt", bus.perf_fetch_cnt, 32'd10);
        chk("perf_flush_cnt", bus.perf_flush_cnt, 32'd2);
`else
        chk("perf_fetch_cnt", bus.perf_fetch_cnt, 32'd0);
        chk("perf_flush_cnt", bus.perf_flush_cnt, 32'd0);
`endif
        repeat (4) tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ifu_prefetch.md
IFU_PREFETCH -- requirements
Module: ifu_prefetch

Interface
REQ-001 SHALL have parameter XLEN, default 32: address and instruction width.
REQ-002 SHALL have parameter RESET_PC, default 32'h80000000: first fetch address after reset.
REQ-003 SHALL have parameter DEPTH, default 4: prefetch buffer entries; power of two, at least 2.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous reset, active-high.
REQ-006 SHALL have port mem_req_valid, output, 1 bit: fetch request present.
REQ-007 SHALL have port mem_req_ready, input, 1 bit: memory accepts the request.
REQ-008 SHALL have port mem_req_addr, output, XLEN bits: fetch address.
REQ-009 SHALL have port mem_rsp_valid, input, 1 bit: instruction word returned, in request order.
REQ-010 SHALL have port mem_rsp_data, input, 32 bits: returned instruction word.
REQ-011 SHALL have port inst_valid, output, 1 bit: buffer head valid.
REQ-012 SHALL have port inst_ready, input, 1 bit: consumer takes the head.
REQ-013 SHALL have port inst_pc, output, XLEN bits: PC of the head entry.
REQ-014 SHALL have port inst, output, 32 bits: instruction word of the head entry.
REQ-015 SHALL have port redirect_valid, input, 1 bit: flush the buffer and restart fetch.
REQ-016 SHALL have port redirect_pc, input, XLEN bits: new fetch PC.
REQ-017 SHALL have ports perf_fetch_cnt and perf_flush_cnt, output, 32 bits each: performance counters.

Function
REQ-018 SHALL consider a request accepted in any cycle where mem_req_valid and mem_req_ready are both high; the next request address SHALL be the accepted address + 4, wrapping modulo 2^XLEN.
REQ-019 SHALL assert mem_req_valid only when (requests in flight + buffer occupancy) < DEPTH, so every response always has a free slot.
REQ-020 SHALL hold mem_req_valid and mem_req_addr stable until acceptance, except in a redirect cycle.
REQ-021 SHALL write each non-discarded response into the buffer together with its request address; the earliest response is the cycle after acceptance, and the entry appears on inst_valid the cycle after the response.
REQ-022 SHALL drive inst_valid, inst_pc and inst directly from the buffer head; the head pops when inst_valid and inst_ready are both high.
REQ-023 SHALL support a push and a pop in the same cycle when the buffer is full; occupancy then stays at DEPTH.
REQ-024 SHALL handle a cycle with redirect_valid high as follows:
- empty the buffer; any pop that cycle is ignored;
- deassert mem_req_valid for that cycle;
- count as stale every in-flight request, including one accepted in that cycle, and discard exactly that many later responses;
- discard any response arriving in that cycle;
- issue redirect_pc starting the next cycle.
REQ-025 SHALL, when redirects occur in consecutive cycles, honour only the last one and accumulate stale counts.
REQ-026 SHALL not add stale responses to occupancy; they SHALL still free their in-flight credit.

Reset
REQ-027 SHALL, while rst is high, drive mem_req_valid=0 and inst_valid=0, set the fetch PC to RESET_PC, and clear occupancy, the in-flight count, the stale count and both perf counters.
REQ-028 SHALL issue RESET_PC on mem_req_valid in the first cycle after rst falls.
REQ-029 SHALL discard any response arriving after reset that belongs to a request issued before reset.

Configuration
REQ-030 SHALL use macro IFU_PREFETCH_PERF_EN to control the performance counters.
REQ-031 SHALL, with IFU_PREFETCH_PERF_EN defined, increment perf_fetch_cnt on each accepted request and perf_flush_cnt on each redirect cycle; both counters wrap at 2^32.
REQ-032 SHALL, without IFU_PREFETCH_PERF_EN, tie both perf counter outputs to 0 and synthesise no counter registers.

Verification
REQ-033 SHALL cover reset release with mem_req_ready=1 and a 1-cycle memory -> addresses 80000000, 80000004, 80000008 on consecutive cycles; inst_pc=80000000 appears 2 cycles after the first request.
REQ-034 SHALL cover inst_ready=0 with DEPTH=4 -> exactly 4 requests issued, then mem_req_valid stays 0; one pop -> exactly one new request.
REQ-035 SHALL cover redirect_pc=80000100 with 2 requests in flight -> the next 2 responses are dropped; inst_pc=80000100 is the first instruction delivered after the redirect.
REQ-036 SHALL cover mem_req_ready=0 for 5 cycles -> mem_req_addr is unchanged throughout; after acceptance the address increments by 4.
REQ-037 SHALL cover a fetch at FFFFFFFC with XLEN=32 -> the next request address is 00000000.
REQ-038 SHALL cover, with IFU_PREFETCH_PERF_EN defined, 10 accepts and 2 redirects -> perf_fetch_cnt=10 and perf_flush_cnt=2; without the macro both read 0.
